mac_arb_resp: RTL
=================

MAC_ARB_RESP -- requirements
Module: mac_arb_resp

Interface
REQ-001 The block SHALL have the following parameters:
- MAC_NUM, default 27, number of MACs in the PEB.
- MAC_ID, default 0, index of this MAC in the ARBMAC_* buses.
- ACT_LEN, default 16, activations per row.
- DATA_W, default 8, signed activation and weight width.
- PSUM_W, default 24, accumulator width.
- IDWEI_W, default 5, weight ID width.
- ROW_W, default 4, activation row ID width.
- IDPSUM_W, default 4, PSUM ID width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. The ports SHALL be as follows:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- ARBMAC_Rst, input, MAC_NUM, one-cycle assignment pulse per MAC.
- ARBMAC_IDWei, input, IDWEI_W*MAC_NUM, weight ID per MAC.
- ARBMAC_IDActRow, input, ROW_W*MAC_NUM, activation row per MAC.
- ARBMAC_IDPSUM, input, IDPSUM_W*MAC_NUM, destination PSUM row per MAC.
- MAC_ReqHelp, output, 1, this MAC is idle and requests work.
- MACMEM_Rd, output, 1, read strobe.
- MACMEM_ActAddr, output, ROW_W+log2(ACT_LEN), activation address.
- MACMEM_WeiAddr, output, IDWEI_W+log2(ACT_LEN), weight address.
- MEMMAC_Act, input, DATA_W, activation data, valid one cycle after MACMEM_Rd.
- MEMMAC_Wei, input, DATA_W, weight data, valid one cycle after MACMEM_Rd.
- MACPSUM_Val, output, 1, partial sum valid.
- MACPSUM_Dat, output, PSUM_W, partial sum.
- MACPSUM_IDPSUM, output, IDPSUM_W, PSUM row tag.
- PSUMMAC_Rdy, input, 1, PSUM side accepts.
- MAC_AsgErr, output, 1, sticky assignment-while-busy flag.

Function
REQ-003 The block SHALL use a four-state FSM: IDLE, FETCH, DRAIN, OUT.
REQ-004 MAC_ReqHelp SHALL be registered and SHALL be 1 exactly when the state is IDLE.
REQ-005 In IDLE, if ARBMAC_Rst[MAC_ID]=1 at edge T, the block SHALL capture its IDWei, IDActRow and IDPSUM slices, clear the accumulator and counter k, and enter FETCH at T+1.
REQ-006 In FETCH, the block SHALL hold MACMEM_Rd=1 for exactly ACT_LEN cycles, with MACMEM_ActAddr = IDActRow*ACT_LEN+k and MACMEM_WeiAddr = IDWei*ACT_LEN+k, k=0..ACT_LEN-1.
REQ-007 The block SHALL register MEMMAC_Act*MEMMAC_Wei as a signed product, sign-extend it, and add it into the accumulator in the cycle after each read; overflow SHALL wrap modulo 2^PSUM_W.
REQ-008 After the last read, the block SHALL go to DRAIN for one cycle to absorb the final data, then enter OUT at T+ACT_LEN+2.
REQ-009 In OUT, MACPSUM_Val SHALL be 1, and MACPSUM_Dat and MACPSUM_IDPSUM SHALL be stable until the cycle PSUMMAC_Rdy=1.
REQ-010 On the first cycle with MACPSUM_Val=1 and PSUMMAC_Rdy=1, the transfer SHALL complete, and the block SHALL enter IDLE on the next edge.
REQ-011 If PSUMMAC_Rdy is already 1 on the first OUT cycle, the OUT state SHALL last exactly one cycle.
REQ-012 ARBMAC_Rst[MAC_ID] outside IDLE SHALL be ignored: the captured IDs and the accumulator SHALL be unchanged.
REQ-013 ARBMAC_Rst bits of other MACs, and the bus slices of other MACs, SHALL have no effect.
REQ-014 An assignment arriving in the same cycle that OUT completes SHALL be ignored, because the state is not yet IDLE.
REQ-015 k SHALL not wrap: the FETCH-to-DRAIN transition SHALL occur when k=ACT_LEN-1.
REQ-016 MACMEM_Rd SHALL be 0 in IDLE, DRAIN and OUT.

Reset
REQ-017 When rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-FETCH and mid-OUT.
REQ-018 On reset, the outputs SHALL take these values:
- MAC_ReqHelp=1.
- MACMEM_Rd=0.
- MACPSUM_Val=0.
- MACMEM_ActAddr, MACMEM_WeiAddr, MACPSUM_Dat, MACPSUM_IDPSUM=0.
- MAC_AsgErr=0.
- The accumulator, k and the captured IDs=0.
REQ-019 A PSUM transfer pending at reset SHALL be dropped without handshake.

Configuration
REQ-020 The macro MAC_ASSIGN_CHK_EN SHALL control the assignment check:
- Defined: MAC_AsgErr SHALL set on any edge where ARBMAC_Rst[MAC_ID]=1 and the state is not IDLE, and SHALL clear only on rst.
- Undefined: MAC_AsgErr SHALL be constant 0 and the check logic SHALL be absent.
- In both cases, the FSM behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover these directed scenarios, all with default parameters:
- Basic assignment: Rst[0] pulse, IDWei=3, IDActRow=2, IDPSUM=5, all act=1, wei=2 -> reads at addresses 32..47 and 48..63, Val at T+18, Dat=32, IDPSUM=5, ReqHelp low T+1..handshake.
- Backpressure: Rdy held 0 for 10 cycles after Val -> Val, Dat and IDPSUM stable for those 10 cycles, IDLE one cycle after Rdy=1.
- Signed wrap: act=-128, wei=-128 for 16 reads with PSUM_W=16 -> Dat=0 (262144 mod 65536).
- Busy assignment: Rst[0] re-pulsed mid-FETCH with IDWei=7 -> addresses unchanged, result unaffected, MAC_AsgErr=1 only if MAC_ASSIGN_CHK_EN is defined.
- Foreign and reset cases: Rst[1] pulsed with MAC_ID=0 -> no response; rst asserted at k=8 -> ReqHelp=1, Rd=0 and Val=0 next cycle, and a fresh assignment then completes normally.

Source files
------------

// File: rtl/mac_arb_resp.sv
// mac_arb_resp: one MAC of the PEB. It accepts a job from the arbiter bus
// while idle, streams ACT_LEN activation/weight pairs from memory, accumulates
// their signed products, and hands the partial sum to the PSUM side with a
// valid/ready handshake.
// Optional feature: define MAC_ASSIGN_CHK_EN to build the sticky
// assignment-while-busy flag MAC_AsgErr; otherwise MAC_AsgErr is tied to 0.
module mac_arb_resp #(
  parameter int MAC_NUM  = 27,
  parameter int MAC_ID   = 0,
  parameter int ACT_LEN  = 16,
  parameter int DATA_W   = 8,
  parameter int PSUM_W   = 24,
  parameter int IDWEI_W  = 5,
  parameter int ROW_W    = 4,
  parameter int IDPSUM_W = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [MAC_NUM-1:0]                   ARBMAC_Rst,
  input  logic [IDWEI_W*MAC_NUM-1:0]           ARBMAC_IDWei,
  input  logic [ROW_W*MAC_NUM-1:0]             ARBMAC_IDActRow,
  input  logic [IDPSUM_W*MAC_NUM-1:0]          ARBMAC_IDPSUM,
  output logic                                 MAC_ReqHelp,
  output logic                                 MACMEM_Rd,
  output logic [ROW_W+$clog2(ACT_LEN)-1:0]     MACMEM_ActAddr,
  output logic [IDWEI_W+$clog2(ACT_LEN)-1:0]   MACMEM_WeiAddr,
  input  logic [DATA_W-1:0]                    MEMMAC_Act,
  input  logic [DATA_W-1:0]                    MEMMAC_Wei,
  output logic                                 MACPSUM_Val,
  output logic [PSUM_W-1:0]                    MACPSUM_Dat,
  output logic [IDPSUM_W-1:0]                  MACPSUM_IDPSUM,
  input  logic                                 PSUMMAC_Rdy,
  output logic                                 MAC_AsgErr
);

  localparam int K_W  = $clog2(ACT_LEN);
  localparam int AA_W = ROW_W + K_W;
  localparam int WA_W = IDWEI_W + K_W;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t                state;
  logic [K_W-1:0]        k;
  logic [IDWEI_W-1:0]    id_wei;
  logic [ROW_W-1:0]      id_row;
  logic [IDPSUM_W-1:0]   id_psum;
  logic                  rd_d;
  logic [PSUM_W-1:0]     acc;

  // Only this MAC's pulse and bus slices matter; the rest of the buses are ignored.
  logic                  asg;
  logic [IDWEI_W-1:0]    wei_sl;
  logic [ROW_W-1:0]      row_sl;
  logic [IDPSUM_W-1:0]   psum_sl;
  logic                  unused_bus;

  assign asg     = ARBMAC_Rst[MAC_ID];
  assign wei_sl  = ARBMAC_IDWei[MAC_ID*IDWEI_W +: IDWEI_W];
  assign row_sl  = ARBMAC_IDActRow[MAC_ID*ROW_W +: ROW_W];
  assign psum_sl = ARBMAC_IDPSUM[MAC_ID*IDPSUM_W +: IDPSUM_W];
  assign unused_bus = ^{ARBMAC_Rst, ARBMAC_IDWei, ARBMAC_IDActRow, ARBMAC_IDPSUM};

  // Product is formed directly at PSUM_W: sign-extending both operands first
  // and truncating the result gives the modulo-2^PSUM_W wrap for free.
  logic signed [DATA_W-1:0] act_s, wei_s;
  logic signed [PSUM_W-1:0] prod_ext;

  assign act_s    = MEMMAC_Act;
  assign wei_s    = MEMMAC_Wei;
  assign prod_ext = PSUM_W'(act_s) * PSUM_W'(wei_s);

  assign MACPSUM_Dat    = acc;
  assign MACPSUM_IDPSUM = id_psum;

  // Control FSM: job capture, read sequencing, drain slot and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      MAC_ReqHelp    <= 1'b1;
      MACMEM_Rd      <= 1'b0;
      MACPSUM_Val    <= 1'b0;
      MACMEM_ActAddr <= '0;
      MACMEM_WeiAddr <= '0;
      k              <= '0;
      id_wei         <= '0;
      id_row         <= '0;
      id_psum        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (asg) begin
            id_wei         <= wei_sl;
            id_row         <= row_sl;
            id_psum        <= psum_sl;
            k              <= '0;
            MACMEM_ActAddr <= AA_W'(row_sl) * AA_W'(ACT_LEN);
            MACMEM_WeiAddr <= WA_W'(wei_sl) * WA_W'(ACT_LEN);
            MACMEM_Rd      <= 1'b1;
            MAC_ReqHelp    <= 1'b0;
            state          <= FETCH;
          end
        end
        FETCH: begin
          if (k == K_W'(ACT_LEN - 1)) begin
            MACMEM_Rd <= 1'b0;
            state     <= DRAIN;
          end else begin
            k              <= k + K_W'(1);
            MACMEM_ActAddr <= MACMEM_ActAddr + AA_W'(1);
            MACMEM_WeiAddr <= MACMEM_WeiAddr + WA_W'(1);
          end
        end
        DRAIN: begin
          MACPSUM_Val <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (PSUMMAC_Rdy) begin
            MACPSUM_Val <= 1'b0;
            MAC_ReqHelp <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulate each returned pair the cycle it arrives (one cycle after its read).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d <= 1'b0;
      acc  <= '0;
    end else begin
      rd_d <= MACMEM_Rd;
      if (state == IDLE && asg)
        acc <= '0;
      else if (rd_d)
        acc <= acc + prod_ext;
    end
  end

`ifdef MAC_ASSIGN_CHK_EN
  logic asg_err;

  // Sticky flag for an assignment pulse that lands while the MAC is busy.
  always_ff @(posedge clk) begin
    if (rst)
      asg_err <= 1'b0;
    else if (asg && state != IDLE)
      asg_err <= 1'b1;
  end

  assign MAC_AsgErr = asg_err;
`else
  assign MAC_AsgErr = 1'b0;
`endif

endmodule
